match_result_queue: RTL and testbench

- Parametrised successor to the string-match engine's result sender.
- Takes per-string match events from the matcher and the star-matcher, formats them into {match, index} result words, and tags each with a string sequence number.
- Buffers results in a DEPTH-entry FIFO and releases them over a valid/ready handshake, so the matcher never stalls on a slow consumer.
- Reports occupancy and a sticky overflow flag.

---
 rtl/match_result_queue.sv | 131 +++++++++++++
 tb/tb_match_result_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/match_result_queue.sv
// match_result_queue: formats per-string match events from the plain and star
// matchers into {match, index, str_id} result words. The words are buffered in
// a DEPTH-entry FIFO and released to a consumer over a valid/ready handshake.
// The block also reports occupancy and a sticky overflow flag for dropped events.
//
// Handshake: the producer side has no stall input. An event is taken at a
// rising edge when ev_ready=1 (count<DEPTH). Otherwise it is dropped and
// flagged in overflow. On the consumer side, a word transfers at a rising edge
// where o_valid & o_ready. While o_valid & !o_ready the word is held stable.
module match_result_queue #(
  parameter int IDX_W = 5,
  parameter int DEPTH = 4,
  parameter int STR_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ev_match_v,
  input  logic                       ev_done,
  input  logic [IDX_W-1:0]           ev_idx,
  input  logic                       ev_head_bol,
  input  logic                       ev_head_eol,
  input  logic                       ev_star_v,
  input  logic                       ev_star_done,
  input  logic [IDX_W-1:0]           ev_stride,
  output logic                       ev_ready,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic                       o_match,
  output logic [IDX_W-1:0]           o_idx,
  output logic [STR_W-1:0]           o_str_id,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic             mem_match [DEPTH];
  logic [IDX_W-1:0] mem_idx   [DEPTH];
  logic [STR_W-1:0] mem_str   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [STR_W-1:0] str_cnt;
  logic             ovf_q;

  logic             ev_any;
  logic             full;
  logic             push;
  logic             drop;
  logic             pop;
  logic             entry_match;
  logic [IDX_W-1:0] entry_idx;

  assign ev_any      = ev_match_v | ev_star_v | ev_done | ev_star_done;
  assign full        = (count_q == CNT_W'(DEPTH));
  assign push        = ev_any & ~full;
  // A pop in the same cycle does not rescue an event that arrives while full.
  assign drop        = ev_any & full;
  assign pop         = o_valid & o_ready;
  assign entry_match = ev_match_v | ev_star_v;

  // Format the result index: plain match wins over star, done-only reports 0.
  always_comb begin
    entry_idx = '0;
    if (ev_match_v) begin
      if ((ev_idx == IDX_W'(1) && ev_head_bol) || (ev_idx == '0 && ev_head_eol))
        entry_idx = '0;
      else
        entry_idx = ev_idx - IDX_W'(1) + {{(IDX_W-1){1'b0}}, ev_head_bol};
    end else if (ev_star_v) begin
      entry_idx = ev_stride;
    end
  end

  // Storage write on push; reset zeroes entries so head outputs read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_match[i] <= 1'b0;
        mem_idx[i]   <= '0;
        mem_str[i]   <= '0;
      end
    end else if (push) begin
      mem_match[wr_ptr] <= entry_match;
      mem_idx[wr_ptr]   <= entry_idx;
      mem_str[wr_ptr]   <= str_cnt;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // String sequence counter advances on every event, dropped or not.
  always_ff @(posedge clk) begin
    if (rst)         str_cnt <= '0;
    else if (ev_any) str_cnt <= str_cnt + STR_W'(1);
  end

  // Sticky overflow; a drop takes precedence over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)          ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (clr_ovf) ovf_q <= 1'b0;
  end

  assign ev_ready = ~full;
  assign o_valid  = (count_q != '0);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign o_match  = mem_match[rd_ptr];
  assign o_idx    = mem_idx[rd_ptr];
  assign o_str_id = mem_str[rd_ptr];

endmodule

// File: tb/tb_match_result_queue.sv
// tb_match_result_queue: directed cases plus randomized traffic, checked
// against a queue-based reference model of the result FIFO.
module tb_match_result_queue;

  localparam int IDX_W = 5;
  localparam int DEPTH = 4;
  localparam int STR_W = 4;
  localparam int W     = 1 + IDX_W + STR_W;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ev_match_v = 1'b0, ev_done = 1'b0;
  logic [IDX_W-1:0] ev_idx = '0, ev_stride = '0;
  logic             ev_head_bol = 1'b0, ev_head_eol = 1'b0;
  logic             ev_star_v = 1'b0, ev_star_done = 1'b0;
  logic             ev_ready, o_valid, o_match, overflow;
  logic             o_ready = 1'b0, clr_ovf = 1'b0;
  logic [IDX_W-1:0] o_idx;
  logic [STR_W-1:0] o_str_id;
  logic [CNT_W-1:0] count;

  match_result_queue #(.IDX_W(IDX_W), .DEPTH(DEPTH), .STR_W(STR_W)) dut (
    .clk(clk), .rst(rst),
    .ev_match_v(ev_match_v), .ev_done(ev_done), .ev_idx(ev_idx),
    .ev_head_bol(ev_head_bol), .ev_head_eol(ev_head_eol),
    .ev_star_v(ev_star_v), .ev_star_done(ev_star_done), .ev_stride(ev_stride),
    .ev_ready(ev_ready), .o_valid(o_valid), .o_ready(o_ready),
    .o_match(o_match), .o_idx(o_idx), .o_str_id(o_str_id),
    .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Scoreboard state.
  logic [W-1:0] exp_q[$];
  int  m_str   = 0;
  bit  m_ovf   = 1'b0;
  bit  known   = 1'b0;
  int  total   = 0;
  int  bad     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Result index from the formatting rules, using plain integer arithmetic.
  function automatic int model_idx();
    int m;
    m = 1 << IDX_W;
    if (ev_match_v) begin
      if ((ev_idx == 1 && ev_head_bol) || (ev_idx == 0 && ev_head_eol)) return 0;
      return (int'(ev_idx) + int'(ev_head_bol) - 1 + m) % m;
    end
    if (ev_star_v) return int'(ev_stride);
    return 0;
  endfunction

  // Check the DUT against the model, advance the model, then take one clock.
  task automatic cycle();
    bit ev, pop, full;
    logic [W-1:0] word;
    if (known) begin
      check("count",    32'(count),    32'(exp_q.size()));
      check("ev_ready", 32'(ev_ready), 32'(exp_q.size() < DEPTH));
      check("o_valid",  32'(o_valid),  32'(exp_q.size() > 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (exp_q.size() > 0)
        check("head", 32'({o_match, o_idx, o_str_id}), 32'(exp_q[0]));
    end
    if (rst) begin
      exp_q.delete();
      m_str = 0;
      m_ovf = 1'b0;
      known = 1'b1;
    end else begin
      ev   = ev_match_v | ev_star_v | ev_done | ev_star_done;
      full = (exp_q.size() == DEPTH);
      pop  = (exp_q.size() > 0) && o_ready;
      word = {1'(ev_match_v | ev_star_v), IDX_W'(model_idx()), STR_W'(m_str % (1 << STR_W))};
      if (pop) void'(exp_q.pop_front());
      if (ev) begin
        if (full) m_ovf = 1'b1;
        else      exp_q.push_back(word);
        m_str++;
      end
      if (!(ev && full) && clr_ovf) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ev_match_v = 0; ev_done = 0; ev_star_v = 0; ev_star_done = 0;
    ev_idx = '0; ev_stride = '0; ev_head_bol = 0; ev_head_eol = 0;
    clr_ovf = 0; rst = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  task automatic plain_ev(input int idx, input bit bol, input bit eol);
    idle_inputs();
    ev_match_v = 1; ev_idx = IDX_W'(idx); ev_head_bol = bol; ev_head_eol = eol;
    cycle();
    idle_inputs();
  endtask

  task automatic drain();
    idle_inputs();
    o_ready = 1;
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) cycle();
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  int corner_idx[4] = '{1, 0, 7, 0};
  bit corner_bol[4] = '{1, 0, 0, 0};
  bit corner_eol[4] = '{0, 1, 0, 0};
  int corner_exp[4] = '{0, 0, 6, 31};

  initial begin
    // Reset state.
    do_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(ev_ready), 32'd1);
    check("rst_head",  32'({o_match, o_idx, o_str_id}), 32'd0);

    // Plain match with start-of-line anchor: one cycle latency.
    o_ready = 0;
    plain_ev(5, 1, 0);
    check("t1_valid", 32'(o_valid), 32'd1);
    check("t1_match", 32'(o_match), 32'd1);
    check("t1_idx",   32'(o_idx),   32'd5);
    check("t1_str",   32'(o_str_id), 32'd0);
    drain();

    // Anchor corners.
    for (int i = 0; i < 4; i++) begin
      o_ready = 0;
      plain_ev(corner_idx[i], corner_bol[i], corner_eol[i]);
      check("corner_idx", 32'(o_idx), 32'(corner_exp[i]));
      drain();
    end

    // Priority between sources.
    o_ready = 0;
    idle_inputs();
    ev_match_v = 1; ev_star_v = 1; ev_idx = 9; ev_stride = 3;
    cycle();
    idle_inputs();
    check("prio_cnt", 32'(count), 32'd1);
    check("prio_idx", 32'(o_idx), 32'd8);
    drain();
    o_ready = 0;
    ev_star_v = 1; ev_stride = 3;
    cycle();
    idle_inputs();
    check("star_idx", 32'(o_idx), 32'd3);
    drain();
    o_ready = 0;
    ev_done = 1; ev_star_done = 1; ev_idx = 4;
    cycle();
    idle_inputs();
    check("done_cnt",   32'(count),   32'd1);
    check("done_match", 32'(o_match), 32'd0);
    check("done_idx",   32'(o_idx),   32'd0);
    drain();

    // Backpressure, overflow and the str_id gap.
    do_reset();
    o_ready = 0;
    for (int i = 0; i < 4; i++) plain_ev(i + 2, 0, 0);
    check("bp_count", 32'(count), 32'd4);
    check("bp_ready", 32'(ev_ready), 32'd0);
    o_ready = 1;
    plain_ev(20, 0, 0);
    check("bp_ovf", 32'(overflow), 32'd1);
    check("bp_count2", 32'(count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      check("bp_str", 32'(o_str_id), 32'(i));
      idle_inputs();
      cycle();
    end
    o_ready = 0;
    plain_ev(10, 0, 0);
    check("gap_str", 32'(o_str_id), 32'd5);
    clr_ovf = 1;
    cycle();
    idle_inputs();
    check("clr_ovf", 32'(overflow), 32'd0);
    drain();

    // Streaming with an event every cycle.
    o_ready = 1;
    for (int i = 0; i < 20; i++) begin
      ev_star_v = 1; ev_stride = IDX_W'($urandom_range(0, 31));
      cycle();
      check("stream_cnt", 32'(count <= 1), 32'd1);
    end
    idle_inputs();
    check("stream_ovf", 32'(overflow), 32'd0);
    drain();

    // Reset mid-stream.
    o_ready = 0;
    for (int i = 0; i < 3; i++) plain_ev(3, 0, 0);
    check("mid_count", 32'(count), 32'd3);
    do_reset();
    check("mid_rst_cnt", 32'(count), 32'd0);
    check("mid_rst_val", 32'(o_valid), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    plain_ev(3, 0, 0);
    check("mid_str", 32'(o_str_id), 32'd0);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      ev_match_v   = ($urandom_range(0, 3) == 0);
      ev_star_v    = ($urandom_range(0, 3) == 0);
      ev_done      = ($urandom_range(0, 5) == 0);
      ev_star_done = ($urandom_range(0, 5) == 0);
      ev_idx       = IDX_W'($urandom_range(0, 31));
      ev_stride    = IDX_W'($urandom_range(0, 31));
      ev_head_bol  = $urandom_range(0, 1);
      ev_head_eol  = $urandom_range(0, 1);
      o_ready      = ($urandom_range(0, 2) != 0);
      clr_ovf      = ($urandom_range(0, 9) == 0);
      rst          = ($urandom_range(0, 99) == 0);
      cycle();
    end
    idle_inputs();
    drain();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
